// File: rtl/segment_capture_pkg.sv
// Shared definitions for the multiplexed digit bus receiver: select codes, field limits, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a; the bus has no flow control and the receiver can never stall the driver.
package segment_capture_pkg;

    // Digit-select codes seen on bytee; all-zero marks a data phase.
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_D0   = 4'b0001;  // low units
    localparam logic [3:0] SEL_D1   = 4'b0010;  // low tens
    localparam logic [3:0] SEL_D2   = 4'b0100;  // high units
    localparam logic [3:0] SEL_D3   = 4'b1000;  // high tens

    // Each rebuilt field is 0..59 in binary.
    localparam int         FIELD_W   = 6;
    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_SEL   = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // Select code expected for digit index idx.
    function automatic logic [3:0] sel_code(input logic [1:0] idx);
        logic [3:0] code;
        case (idx)
            2'd0:    code = SEL_D0;
            2'd1:    code = SEL_D1;
            2'd2:    code = SEL_D2;
            default: code = SEL_D3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/segment_capture_bcd2_to_bin.sv
// Converts one two-digit BCD field to binary and flags digits outside 0..5 / 0..9.
// Latency: combinational.
// Backpressure: none.
// Ports: i_tens, i_units (BCD digits) -> o_bin (binary field), o_in_range (both digits legal).
module bcd2_to_bin
    import segment_capture_pkg::*;
(
    input  logic [3:0]         i_tens,
    input  logic [3:0]         i_units,
    output logic [FIELD_W-1:0] o_bin,
    output logic               o_in_range
);

    logic [FIELD_W-1:0] w_tens;
    logic [FIELD_W-1:0] w_tens_x10;

    assign w_tens     = {2'b00, i_tens};
    // tens*10 as shift-and-add; a legal field never exceeds 59 so 6 bits suffice.
    assign w_tens_x10 = (w_tens << 3) + (w_tens << 1);
    assign o_bin      = w_tens_x10 + {2'b00, i_units};
    assign o_in_range = (i_tens <= TENS_MAX) && (i_units <= UNITS_MAX);

endmodule

// File: rtl/segment_capture.sv
// Receives the 8-phase select/data digit bus, captures four BCD digits and rebuilds {high,low}.
// Latency: data_valid two clocks after the cycle that samples the high-tens digit.
// Backpressure: none; the bus is free-running, malformed or stalled frames are dropped with frame_error.
// Ports: clock, reset (async active-low); bytee (select/data phase), segment (digit on data phase);
//        data_out (last good frame), data_valid / frame_error (one-cycle pulses), link_up.
module segment_capture
    import segment_capture_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SETTLE_CYCLES  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  bytee,
    input  logic [6:0]  segment,
    output logic [11:0] data_out,
    output logic        data_valid,
    output logic        frame_error,
    output logic        link_up
);

    localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam int              SW           = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0]   TO_MAX       = TW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0]   SETTLE_MAX   = SW'(SETTLE_CYCLES);
    localparam bit              SAMPLE_FIRST = (SETTLE_CYCLES == 0);

    state_t             r_state;
    logic [1:0]         r_exp;
    logic               r_sampled;
    logic [SW-1:0]      r_settle;
    logic [TW-1:0]      r_to_cnt;
    logic [3:0]         r_bytee_q;
    logic [3:0]         r_digit [4];
    logic [11:0]        r_data_out;
    logic               r_data_valid;
    logic               r_frame_error;
    logic               r_link_up;

    logic               w_change;
    logic               w_to_hit;
    logic               w_is_zero;
    logic               w_is_d0;
    logic [3:0]         w_exp_sel;
    logic [3:0]         w_next_sel;
    logic               w_seg_bad;
    logic               w_settled;
    logic               w_sample;
    state_t             w_resync_state;
    logic [FIELD_W-1:0] w_lo_bin;
    logic [FIELD_W-1:0] w_hi_bin;
    logic               w_lo_ok;
    logic               w_hi_ok;

    bcd2_to_bin u_lo (
        .i_tens     (r_digit[1]),
        .i_units    (r_digit[0]),
        .o_bin      (w_lo_bin),
        .o_in_range (w_lo_ok)
    );

    bcd2_to_bin u_hi (
        .i_tens     (r_digit[3]),
        .i_units    (r_digit[2]),
        .o_bin      (w_hi_bin),
        .o_in_range (w_hi_ok)
    );

    assign w_change   = (bytee != r_bytee_q);
    // Fires once, on the cycle the idle count would reach its limit.
    assign w_to_hit   = !w_change && (r_to_cnt == TO_MAX - 1'b1);
    assign w_is_zero  = (bytee == SEL_NONE);
    assign w_is_d0    = (bytee == SEL_D0);
    assign w_exp_sel  = sel_code(r_exp);
    assign w_next_sel = sel_code(r_exp + 2'd1);
    assign w_seg_bad  = |segment[6:4];

    // The first data cycle is seen while still in SEL; r_settle counts data cycles already seen,
    // so the sample lands on data cycle index SETTLE_CYCLES.
    assign w_settled  = (r_state == ST_SEL) ? SAMPLE_FIRST : (r_settle >= SETTLE_MAX);
    assign w_sample   = w_is_zero && w_settled &&
                        ((r_state == ST_SEL) || ((r_state == ST_DATA) && !r_sampled));

    // A stray 0001 is the start of a new frame, so recover straight into SEL instead of HUNT.
    assign w_resync_state = w_is_d0 ? ST_SEL : ST_HUNT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_HUNT;
            r_exp         <= '0;
            r_sampled     <= 1'b0;
            r_settle      <= '0;
            r_to_cnt      <= '0;
            r_bytee_q     <= '0;
            for (int k = 0; k < 4; k++) r_digit[k] <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_link_up     <= 1'b0;
        end else begin
            r_bytee_q     <= bytee;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;

            if (w_change) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_to_hit) begin
                // A stalled bus overrides whatever the frame was doing.
                r_link_up <= 1'b0;
                if (r_state != ST_HUNT) begin
                    r_frame_error <= 1'b1;
                    r_state       <= ST_HUNT;
                    r_exp         <= '0;
                    r_sampled     <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_is_d0) begin
                            r_state <= ST_SEL;
                            r_exp   <= '0;
                        end
                    end

                    ST_SEL, ST_DATA: begin
                        if (w_is_zero) begin
                            if (r_state == ST_SEL) begin
                                r_state   <= ST_DATA;
                                r_sampled <= 1'b0;
                                r_settle  <= SW'(1);
                            end else if (!r_sampled && !w_sample) begin
                                r_settle <= r_settle + 1'b1;
                            end
                            if (w_sample) begin
                                if (w_seg_bad) begin
                                    r_frame_error <= 1'b1;
                                    r_state       <= ST_HUNT;
                                    r_exp         <= '0;
                                    r_sampled     <= 1'b0;
                                end else begin
                                    r_digit[r_exp] <= segment[3:0];
                                    r_sampled      <= 1'b1;
                                    if (r_exp == 2'd3) r_state <= ST_CHECK;
                                end
                            end
                        end else if ((r_state == ST_SEL) && (bytee == w_exp_sel)) begin
                            // Select phase still running.
                        end else if ((r_state == ST_DATA) && r_sampled && (bytee == w_next_sel)) begin
                            r_state <= ST_SEL;
                            r_exp   <= r_exp + 2'd1;
                        end else begin
                            // Non-one-hot select, out-of-order select, or data phase too short.
                            r_frame_error <= 1'b1;
                            r_state       <= w_resync_state;
                            r_exp         <= '0;
                            r_sampled     <= 1'b0;
                        end
                    end

                    ST_CHECK: begin
                        if (w_lo_ok && w_hi_ok) begin
                            r_data_out   <= {w_hi_bin, w_lo_bin};
                            r_data_valid <= 1'b1;
                            r_link_up    <= 1'b1;
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                        r_state   <= w_resync_state;
                        r_exp     <= '0;
                        r_sampled <= 1'b0;
                    end

                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign link_up     = r_link_up;

endmodule

// File: tb/tb_segment_capture.sv
// Directed bench for segment_capture: drives the digit bus frame by frame and checks outputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_segment_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  bytee;
    logic [6:0]  segment;
    logic [11:0] data_out;
    logic        data_valid;
    logic        frame_error;
    logic        link_up;

    int n_checks    = 0;
    int n_pass      = 0;
    int dv_cnt      = 0;
    int fe_cnt      = 0;
    int overlap_cnt = 0;

    always #5 clock = ~clock;

    segment_capture #(
        .TIMEOUT_CYCLES (4096),
        .SETTLE_CYCLES  (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bytee       (bytee),
        .segment     (segment),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .link_up     (link_up)
    );

    // One clock; outputs are observed 1 ns after the edge and pulses are tallied.
    task automatic tick();
        @(posedge clock);
        #1;
        if (data_valid) dv_cnt++;
        if (frame_error) fe_cnt++;
        if (data_valid && frame_error) overlap_cnt++;
    endtask

    task automatic phase(input logic [3:0] b, input logic [6:0] s, input int n);
        bytee   = b;
        segment = s;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input int first_len, input int len);
        phase(4'b0001, 7'h00, first_len);
        phase(4'b0000, {3'b000, d0}, len);
        phase(4'b0010, 7'h00, len);
        phase(4'b0000, {3'b000, d1}, len);
        phase(4'b0100, 7'h00, len);
        phase(4'b0000, {3'b000, d2}, len);
        phase(4'b1000, 7'h00, len);
        phase(4'b0000, {3'b000, d3}, len);
    endtask

    task automatic clear_counts();
        dv_cnt = 0;
        fe_cnt = 0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        bytee   = 4'b0000;
        segment = 7'h00;
        #3;
        n_checks++; if (data_out !== 12'h000) $display("FAIL reset_data_out: got %h expected %h", data_out, 12'h000); else n_pass++;
        n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b expected 0", data_valid); else n_pass++;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error: got %b expected 0", frame_error); else n_pass++;
        n_checks++; if (link_up !== 1'b0) $display("FAIL reset_link_up: got %b expected 0", link_up); else n_pass++;
        repeat (3) tick();
        reset = 1'b1;
        phase(4'b0000, 7'h00, 2);
    endtask

    // low=37, high=12 -> {6'd12,6'd37} = 12'h325
    task automatic test_basic();
        clear_counts();
        send_frame(4'd7, 4'd3, 4'd2, 4'd1, 2, 2);
        n_checks++; if (data_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", data_valid); else n_pass++;
        tick();
        n_checks++; if (data_valid !== 1'b1) $display("FAIL basic_valid_latency: got %b expected 1", data_valid); else n_pass++;
        n_checks++; if (data_out !== 12'h325) $display("FAIL basic_data_out: got %h expected %h", data_out, 12'h325); else n_pass++;
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (dv_cnt !== 1) $display("FAIL basic_valid_count: got %0d expected 1", dv_cnt); else n_pass++;
        n_checks++; if (fe_cnt !== 0) $display("FAIL basic_error_count: got %0d expected 0", fe_cnt); else n_pass++;
        n_checks++; if (link_up !== 1'b1) $display("FAIL basic_link_up: got %b expected 1", link_up); else n_pass++;
    endtask

    // Low tens = 6 is rejected; then 59:59 -> 12'hEFB
    task automatic test_range();
        clear_counts();
        send_frame(4'd4, 4'd6, 4'd0, 4'd1, 2, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (fe_cnt !== 1) $display("FAIL range_error_count: got %0d expected 1", fe_cnt); else n_pass++;
        n_checks++; if (dv_cnt !== 0) $display("FAIL range_valid_count: got %0d expected 0", dv_cnt); else n_pass++;
        n_checks++; if (data_out !== 12'h325) $display("FAIL range_data_held: got %h expected %h", data_out, 12'h325); else n_pass++;
        clear_counts();
        send_frame(4'd9, 4'd5, 4'd9, 4'd5, 2, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (dv_cnt !== 1) $display("FAIL max_valid_count: got %0d expected 1", dv_cnt); else n_pass++;
        n_checks++; if (data_out !== 12'hEFB) $display("FAIL max_data_out: got %h expected %h", data_out, 12'hEFB); else n_pass++;
    endtask

    task automatic test_skip_resync();
        // d1 skipped; the next frame starts right away and is accepted (high 43, low 21 -> 12'hAD5).
        clear_counts();
        phase(4'b0001, 7'h00, 2);
        phase(4'b0000, 7'h04, 2);
        phase(4'b0100, 7'h00, 2);
        send_frame(4'd1, 4'd2, 4'd3, 4'd4, 2, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (fe_cnt !== 1) $display("FAIL skip_error_count: got %0d expected 1", fe_cnt); else n_pass++;
        n_checks++; if (dv_cnt !== 1) $display("FAIL skip_valid_count: got %0d expected 1", dv_cnt); else n_pass++;
        n_checks++; if (data_out !== 12'hAD5) $display("FAIL skip_data_out: got %h expected %h", data_out, 12'hAD5); else n_pass++;
        // Out-of-order 0001 lasting one clock must resync in place (high 25, low 8 -> 12'h648).
        clear_counts();
        phase(4'b0001, 7'h00, 2);
        phase(4'b0000, 7'h05, 2);
        phase(4'b0010, 7'h00, 2);
        phase(4'b0000, 7'h06, 2);
        send_frame(4'd8, 4'd0, 4'd5, 4'd2, 1, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (fe_cnt !== 1) $display("FAIL resync_error_count: got %0d expected 1", fe_cnt); else n_pass++;
        n_checks++; if (dv_cnt !== 1) $display("FAIL resync_valid_count: got %0d expected 1", dv_cnt); else n_pass++;
        n_checks++; if (data_out !== 12'h648) $display("FAIL resync_data_out: got %h expected %h", data_out, 12'h648); else n_pass++;
    endtask

    task automatic test_bad_bus();
        // 0011 mid-frame; the rest of the frame without a fresh 0001 must be ignored.
        clear_counts();
        phase(4'b0001, 7'h00, 2);
        phase(4'b0000, 7'h01, 2);
        phase(4'b0011, 7'h00, 2);
        phase(4'b0000, 7'h02, 2);
        phase(4'b0010, 7'h00, 2);
        phase(4'b0000, 7'h03, 2);
        phase(4'b0100, 7'h00, 2);
        phase(4'b0000, 7'h04, 2);
        phase(4'b1000, 7'h00, 2);
        phase(4'b0000, 7'h05, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (fe_cnt !== 1) $display("FAIL onehot_error_count: got %0d expected 1", fe_cnt); else n_pass++;
        n_checks++; if (dv_cnt !== 0) $display("FAIL onehot_hunt_valid: got %0d expected 0", dv_cnt); else n_pass++;
        // Nonzero upper segment bits at the sample.
        clear_counts();
        phase(4'b0001, 7'h00, 2);
        phase(4'b0000, 7'h13, 2);
        phase(4'b0000, 7'h00, 2);
        n_checks++; if (fe_cnt !== 1) $display("FAIL segbits_error_count: got %0d expected 1", fe_cnt); else n_pass++;
        n_checks++; if (data_out !== 12'h648) $display("FAIL segbits_data_held: got %h expected %h", data_out, 12'h648); else n_pass++;
        // One-clock data phase is shorter than the settle time.
        clear_counts();
        phase(4'b0001, 7'h00, 2);
        phase(4'b0000, 7'h01, 1);
        phase(4'b0010, 7'h00, 2);
        phase(4'b0000, 7'h00, 2);
        n_checks++; if (fe_cnt !== 1) $display("FAIL short_data_error_count: got %0d expected 1", fe_cnt); else n_pass++;
        // high 23, low 45 -> 12'h5ED
        clear_counts();
        send_frame(4'd5, 4'd4, 4'd3, 4'd2, 2, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (dv_cnt !== 1) $display("FAIL after_bad_valid_count: got %0d expected 1", dv_cnt); else n_pass++;
        n_checks++; if (data_out !== 12'h5ED) $display("FAIL after_bad_data_out: got %h expected %h", data_out, 12'h5ED); else n_pass++;
    endtask

    task automatic test_timeout();
        logic lu_before;
        lu_before = 1'b0;
        clear_counts();
        phase(4'b0001, 7'h00, 2);
        phase(4'b0000, 7'h03, 2);
        bytee   = 4'b0010;
        segment = 7'h00;
        // The edge that sees 0010 starts the idle count; the limit is reached 4096 edges later.
        for (int i = 0; i < 4096; i++) begin
            tick();
            if (i == 4095) lu_before = link_up;
        end
        n_checks++; if (fe_cnt !== 0) $display("FAIL timeout_early_error: got %0d expected 0", fe_cnt); else n_pass++;
        n_checks++; if (lu_before !== 1'b1) $display("FAIL timeout_link_before: got %b expected 1", lu_before); else n_pass++;
        tick();
        n_checks++; if (frame_error !== 1'b1) $display("FAIL timeout_error_pulse: got %b expected 1", frame_error); else n_pass++;
        n_checks++; if (link_up !== 1'b0) $display("FAIL timeout_link_down: got %b expected 0", link_up); else n_pass++;
        n_checks++; if (data_out !== 12'h5ED) $display("FAIL timeout_data_held: got %h expected %h", data_out, 12'h5ED); else n_pass++;
        tick();
        n_checks++; if (frame_error !== 1'b0) $display("FAIL timeout_pulse_width: got %b expected 0", frame_error); else n_pass++;
        // high 8, low 16 -> 12'h210
        send_frame(4'd6, 4'd1, 4'd8, 4'd0, 2, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (data_out !== 12'h210) $display("FAIL timeout_recover_data: got %h expected %h", data_out, 12'h210); else n_pass++;
        n_checks++; if (link_up !== 1'b1) $display("FAIL timeout_link_recover: got %b expected 1", link_up); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        phase(4'b0001, 7'h00, 2);
        phase(4'b0000, 7'h09, 2);
        phase(4'b0010, 7'h00, 2);
        phase(4'b0000, 7'h05, 2);
        phase(4'b0100, 7'h00, 2);
        phase(4'b0000, 7'h03, 1);
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (data_out !== 12'h000) $display("FAIL midreset_data_out: got %h expected %h", data_out, 12'h000); else n_pass++;
        n_checks++; if (link_up !== 1'b0) $display("FAIL midreset_link_up: got %b expected 0", link_up); else n_pass++;
        n_checks++; if ((data_valid | frame_error) !== 1'b0) $display("FAIL midreset_pulses: got %b expected 0", data_valid | frame_error); else n_pass++;
        repeat (2) tick();
        reset = 1'b1;
        // Remainder of the interrupted frame must not complete anything.
        phase(4'b0000, 7'h03, 1);
        phase(4'b1000, 7'h00, 2);
        phase(4'b0000, 7'h01, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (dv_cnt !== 0) $display("FAIL midreset_stale_valid: got %0d expected 0", dv_cnt); else n_pass++;
        n_checks++; if (fe_cnt !== 0) $display("FAIL midreset_stale_error: got %0d expected 0", fe_cnt); else n_pass++;
        // high 19, low 42 -> 12'h4EA
        send_frame(4'd2, 4'd4, 4'd9, 4'd1, 2, 2);
        phase(4'b0000, 7'h00, 3);
        n_checks++; if (dv_cnt !== 1) $display("FAIL midreset_new_valid: got %0d expected 1", dv_cnt); else n_pass++;
        n_checks++; if (data_out !== 12'h4EA) $display("FAIL midreset_new_data: got %h expected %h", data_out, 12'h4EA); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_skip_resync();
        test_bad_bus();
        test_timeout();
        test_reset_mid_frame();
        n_checks++; if (overlap_cnt !== 0) $display("FAIL valid_error_overlap: got %0d expected 0", overlap_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
